// File: rtl/hpi_pkg.sv
// hpi_pkg: shared types and constants for the CY7C67200 HPI burst master.
//   hpi_state_e       controller FSM states (StChipRst only reachable with HPI_RESET_SEQ_EN)
//   HPI_REG_*         HPI register selects driven on otg_hpi_address
//   is_addr_phase()   true in the address-write phase states
//   is_data_phase()   true in the data-access phase states
package hpi_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StASetup,
        StAStrobe,
        StAHold,
        StDSetup,
        StDStrobe,
        StDHold,
        StDone,
        StChipRst
    } hpi_state_e;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDR    = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    function automatic logic is_addr_phase(hpi_state_e s);
        return (s == StASetup) || (s == StAStrobe) || (s == StAHold);
    endfunction

    function automatic logic is_data_phase(hpi_state_e s);
        return (s == StDSetup) || (s == StDStrobe) || (s == StDHold);
    endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// hpi_phase_timer: loadable down-counter with zero flag, shared by every HPI phase.
//   clk         system clock
//   reset_n     synchronous active-low reset (counter takes RESET_VALUE)
//   load        load load_value this cycle (has priority over counting)
//   load_value  value to load (phase length minus one)
//   zero        counter is at zero; the owning phase ends this cycle
module hpi_phase_timer #(
    parameter int unsigned W           = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= W'(RESET_VALUE);
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/hpi_burst_ctrl.sv
// hpi_burst_ctrl: HPI master for the CY7C67200. Turns burst / direct-register commands into
// timed otg_hpi address, chip-select, read and write strobes and owns the data output enable.
// Optional feature macro: HPI_RESET_SEQ_EN adds a chip reset pulse of RESET_CYC cycles after
// reset_reset_n is released.
//   clk_clk, reset_reset_n       clock, synchronous active-low reset
//   cmd_*                        command port (valid/ready, write, direct, addr, len)
//   wr_valid/wr_ready/wr_data    write data stream, one word per data phase
//   rd_valid/rd_data             read data, one-cycle pulse per word, no backpressure
//   busy, done                   not idle / one-cycle completion pulse
//   otg_hpi_*                    HPI pins (address, cs_n, r_n, w_n, reset_n, data out/oe/in)
module hpi_burst_ctrl
    import hpi_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned RESET_CYC  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_direct,
    input  logic [15:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        otg_hpi_address,
    output logic              otg_hpi_cs_n,
    output logic              otg_hpi_r_n,
    output logic              otg_hpi_w_n,
    output logic              otg_hpi_reset_n,
    output logic [DATA_W-1:0] otg_hpi_data_out,
    output logic              otg_hpi_data_oe,
    input  logic [DATA_W-1:0] otg_hpi_data_in
);

`ifdef HPI_RESET_SEQ_EN
    localparam hpi_state_e  RESET_STATE = StChipRst;
    // Timer starts at RESET_CYC so the pulse lasts RESET_CYC full cycles after release.
    localparam int unsigned RST_LOAD    = RESET_CYC;
`else
    localparam hpi_state_e  RESET_STATE = StIdle;
    localparam int unsigned RST_LOAD    = 0;
`endif

    localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_SHT = (MAX_SH > STROBE_CYC) ? MAX_SH : STROBE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SHT > RESET_CYC) ? MAX_SHT : RESET_CYC;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

    hpi_state_e          state_q, state_d;
    logic                write_q;
    logic                direct_q;
    logic [1:0]          reg_sel_q;
    logic [LEN_W-1:0]    count_q;
    logic [DATA_W-1:0]   data_q;
    logic                have_word_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;

    logic                timer_load;
    logic [TIMER_W-1:0]  timer_value;
    logic                timer_zero;
    logic                accept;
    logic                wr_take;
    logic                stall;
    logic                rd_sample;
    logic                run;
    logic                in_addr;
    logic                in_data;

    hpi_phase_timer #(
        .W           (TIMER_W),
        .RESET_VALUE (RST_LOAD)
    ) u_timer (
        .clk        (clk_clk),
        .reset_n    (reset_reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        wr_take   = 1'b0;
        stall     = 1'b0;
        rd_sample = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_direct ? StDSetup : StASetup;
                end
            end
            StASetup:  if (timer_zero) state_d = StAStrobe;
            StAStrobe: if (timer_zero) state_d = StAHold;
            StAHold: begin
                if (timer_zero) state_d = (count_q == '0) ? StDone : StDSetup;
            end
            StDSetup: begin
                // Writes wait here with CS released until the word is available.
                if (write_q && !have_word_q) begin
                    if (wr_valid) wr_take = 1'b1;
                    else          stall   = 1'b1;
                end
                if (!stall && timer_zero) state_d = StDStrobe;
            end
            StDStrobe: begin
                if (timer_zero) begin
                    rd_sample = !write_q;
                    state_d   = StDHold;
                end
            end
            StDHold: begin
                if (timer_zero) state_d = (count_q <= LEN_W'(1)) ? StDone : StDSetup;
            end
            StDone: state_d = StIdle;
`ifdef HPI_RESET_SEQ_EN
            StChipRst: if (timer_zero) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

        // Stall reloads the setup count so setup restarts once data arrives.
        timer_load = stall || (state_d != state_q);
        case (state_d)
            StASetup, StDSetup:   timer_value = TIMER_W'(SETUP_CYC - 1);
            StAStrobe, StDStrobe: timer_value = TIMER_W'(STROBE_CYC - 1);
            StAHold, StDHold:     timer_value = TIMER_W'(HOLD_CYC - 1);
            StChipRst:            timer_value = TIMER_W'(RESET_CYC - 1);
            default:              timer_value = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= RESET_STATE;
            write_q     <= 1'b0;
            direct_q    <= 1'b0;
            reg_sel_q   <= 2'd0;
            count_q     <= '0;
            data_q      <= '0;
            have_word_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_sample;
            if (accept) begin
                write_q     <= cmd_write;
                direct_q    <= cmd_direct;
                reg_sel_q   <= cmd_addr[1:0];
                count_q     <= cmd_direct ? LEN_W'(1) : cmd_len;
                have_word_q <= 1'b0;
                // The address phase drives the chip address as its write data.
                if (!cmd_direct) data_q <= DATA_W'(cmd_addr);
            end
            if (wr_take) begin
                data_q      <= wr_data;
                have_word_q <= 1'b1;
            end
            if (rd_sample) rd_data_q <= otg_hpi_data_in;
            if ((state_q == StDHold) && timer_zero) begin
                have_word_q <= 1'b0;
                if (count_q != '0) count_q <= count_q - 1'b1;
            end
        end
    end

    // Pin outputs are forced inactive while reset is asserted.
    assign run     = reset_reset_n;
    assign in_addr = is_addr_phase(state_q);
    assign in_data = is_data_phase(state_q);

    assign cmd_ready        = run && (state_q == StIdle);
    assign busy             = run && (state_q != StIdle);
    assign done             = run && (state_q == StDone);
    assign wr_ready         = run && (state_q == StDSetup) && write_q && !have_word_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign otg_hpi_data_out = data_q;

    always_comb begin
        otg_hpi_address = 2'd0;
        if (run && in_addr)      otg_hpi_address = HPI_REG_ADDR;
        else if (run && in_data) otg_hpi_address = direct_q ? reg_sel_q : HPI_REG_DATA;
    end

    assign otg_hpi_cs_n    = !(run && (in_addr || in_data) && !stall);
    assign otg_hpi_w_n     = !(run && ((state_q == StAStrobe) ||
                                       ((state_q == StDStrobe) && write_q)));
    assign otg_hpi_r_n     = !(run && (state_q == StDStrobe) && !write_q);
    assign otg_hpi_data_oe = run && (in_addr || (in_data && write_q && !stall));

`ifdef HPI_RESET_SEQ_EN
    assign otg_hpi_reset_n = !(run && (state_q == StChipRst));
`else
    assign otg_hpi_reset_n = 1'b1;
`endif

endmodule

// File: tb/tb_hpi_burst_ctrl.sv
// tb_hpi_burst_ctrl: directed self-checking bench for hpi_burst_ctrl (default parameters).
// Also builds with HPI_RESET_SEQ_EN, expecting the chip reset pulse after each reset release.
module tb_hpi_burst_ctrl;
    import hpi_pkg::*;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned LEN_W     = 8;
    localparam int unsigned RESET_CYC = 16;
`ifdef HPI_RESET_SEQ_EN
    localparam int EXP_RST_LOW = RESET_CYC;
`else
    localparam int EXP_RST_LOW = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_reset_n;
    logic              cmd_valid, cmd_ready, cmd_write, cmd_direct;
    logic [15:0]       cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy, done;
    logic [1:0]        otg_hpi_address;
    logic              otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_reset_n;
    logic [DATA_W-1:0] otg_hpi_data_out;
    logic              otg_hpi_data_oe;
    logic [DATA_W-1:0] hpi_din;

    always #5 clk = ~clk;

    hpi_burst_ctrl #(
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .SETUP_CYC  (1),
        .STROBE_CYC (2),
        .HOLD_CYC   (1),
        .RESET_CYC  (RESET_CYC)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (reset_reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_direct       (cmd_direct),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .busy             (busy),
        .done             (done),
        .otg_hpi_address  (otg_hpi_address),
        .otg_hpi_cs_n     (otg_hpi_cs_n),
        .otg_hpi_r_n      (otg_hpi_r_n),
        .otg_hpi_w_n      (otg_hpi_w_n),
        .otg_hpi_reset_n  (otg_hpi_reset_n),
        .otg_hpi_data_out (otg_hpi_data_out),
        .otg_hpi_data_oe  (otg_hpi_data_oe),
        .otg_hpi_data_in  (hpi_din)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Bus monitor / chip model state
    logic [1:0]  ev_addr [16];
    logic [15:0] ev_data [16];
    logic [15:0] rd_got  [8];
    logic [15:0] words   [8];
    logic [15:0] rd_vals [4];
    int ev_cnt, rd_cnt, cs_low, oe_data, rd_strobes, done_cnt, rd_idx, wr_k;
    bit take, prev_w, prev_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        ev_cnt = 0; rd_cnt = 0; cs_low = 0; oe_data = 0; rd_strobes = 0; done_cnt = 0;
        rd_idx = 0; wr_k = 0; take = 1'b0; prev_w = 1'b1; prev_r = 1'b1;
        hpi_din = rd_vals[0];
        wr_data = words[0];
    endtask

    // Called right after a falling edge: feeds write data, models chip reads, logs the bus.
    task automatic sample_cycle();
        if (take) begin
            if (wr_k < 7) wr_k++;
            wr_data = words[wr_k];
            take = 1'b0;
        end
        if (!otg_hpi_w_n && prev_w) begin
            if (ev_cnt < 16) begin
                ev_addr[ev_cnt] = otg_hpi_address;
                ev_data[ev_cnt] = otg_hpi_data_out;
            end
            ev_cnt++;
        end
        if (!otg_hpi_r_n && prev_r) rd_strobes++;
        if (otg_hpi_r_n && !prev_r) begin
            if (rd_idx < 3) rd_idx++;
            hpi_din = rd_vals[rd_idx];
        end
        if (rd_valid) begin
            if (rd_cnt < 8) rd_got[rd_cnt] = rd_data;
            rd_cnt++;
        end
        if (!otg_hpi_cs_n) cs_low++;
        if (otg_hpi_data_oe && (otg_hpi_address == HPI_REG_DATA)) oe_data++;
        if (done) done_cnt++;
        take   = wr_valid && wr_ready;
        prev_w = otg_hpi_w_n;
        prev_r = otg_hpi_r_n;
    endtask

    task automatic issue(input logic wr, input logic dir, input logic [15:0] addr,
                         input logic [7:0] len);
        @(negedge clk);
        cmd_write = wr; cmd_direct = dir; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Cycle 1 is the accept cycle; returns the cycle number in which done is seen (0 = never).
    task automatic run_to_done(input int start_n, output int done_at);
        int n;
        n = start_n;
        done_at = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            sample_cycle();
            if (done) begin
                done_at = n;
                break;
            end
        end
        @(negedge clk);
        sample_cycle();
    endtask

    task automatic release_wait(output int low_cnt, output int ready);
        reset_reset_n = 1'b1;
        low_cnt = 0;
        ready = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!otg_hpi_reset_n) low_cnt++;
            if (done) done_cnt++;
            if (cmd_ready) begin
                ready = 1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, low, ok, stall_hi;
        reset_reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_direct = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) words[i] = 16'h0;
        for (int i = 0; i < 4; i++) rd_vals[i] = 16'hDEAD;
        clear_mon();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_flags", {busy, done, rd_valid, wr_ready}, 4'b0000);
        check("rst_pins", {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_reset_n,
                           otg_hpi_data_oe}, 5'b11110);
        check("rst_addr", otg_hpi_address, 2'd0);
        release_wait(low, ok);
        check("rst_seq_low", low, EXP_RST_LOW);
        check("rst_ready", ok, 1);
        check("rst_data_regs", {otg_hpi_data_out, rd_data}, 32'h0);

        // Burst write 0x1000, 3 words
        words[0] = 16'h00A1; words[1] = 16'h00B2; words[2] = 16'h00C3; words[3] = 16'h0;
        wr_valid = 1'b1;
        clear_mon();
        issue(1'b1, 1'b0, 16'h1000, 8'd3);
        run_to_done(1, d);
        check("bw_done_cycle", d, 18);
        check("bw_ev_cnt", ev_cnt, 4);
        check("bw_ev0", {ev_addr[0], ev_data[0]}, {2'd2, 16'h1000});
        check("bw_ev1", {ev_addr[1], ev_data[1]}, {2'd0, 16'h00A1});
        check("bw_ev2", {ev_addr[2], ev_data[2]}, {2'd0, 16'h00B2});
        check("bw_ev3", {ev_addr[3], ev_data[3]}, {2'd0, 16'h00C3});
        check("bw_cs_low", cs_low, 16);
        check("bw_oe_data", oe_data, 12);
        check("bw_done_cnt", done_cnt, 1);
        check("bw_idle", {busy, done, cmd_ready}, 3'b001);

        // Burst read 0x2000, 2 words
        wr_valid = 1'b0;
        rd_vals[0] = 16'h1234; rd_vals[1] = 16'h5678; rd_vals[2] = 16'hDEAD;
        clear_mon();
        issue(1'b0, 1'b0, 16'h2000, 8'd2);
        run_to_done(1, d);
        check("br_done_cycle", d, 14);
        check("br_rd_cnt", rd_cnt, 2);
        check("br_rd0", rd_got[0], 16'h1234);
        check("br_rd1", rd_got[1], 16'h5678);
        check("br_rd_strobes", rd_strobes, 2);
        check("br_ev_cnt", ev_cnt, 1);
        check("br_ev0", {ev_addr[0], ev_data[0]}, {2'd2, 16'h2000});
        check("br_oe_data", oe_data, 0);

        // Direct write 0x0001 to mailbox
        words[0] = 16'h0001;
        wr_valid = 1'b1;
        clear_mon();
        issue(1'b1, 1'b1, 16'h0001, 8'd0);
        run_to_done(1, d);
        check("dw_done_cycle", d, 6);
        check("dw_ev_cnt", ev_cnt, 1);
        check("dw_ev0", {ev_addr[0], ev_data[0]}, {HPI_REG_MAILBOX, 16'h0001});
        check("dw_cs_low", cs_low, 4);

        // Direct write with data withheld for 5 cycles
        words[0] = 16'hBEEF;
        wr_valid = 1'b0;
        clear_mon();
        issue(1'b1, 1'b1, 16'h0001, 8'd0);
        stall_hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (otg_hpi_cs_n && wr_ready && busy && !otg_hpi_data_oe) stall_hi++;
        end
        check("st_stall_cycles", stall_hi, 5);
        @(posedge clk);
        #1 wr_valid = 1'b1;
        run_to_done(6, d);
        check("st_done_cycle", d, 11);
        check("st_ev_cnt", ev_cnt, 1);
        check("st_ev0", {ev_addr[0], ev_data[0]}, {2'd1, 16'hBEEF});
        check("st_cs_low", cs_low, 4);

        // Reset asserted during the first data strobe of a burst write
        words[0] = 16'h0011; words[1] = 16'h0022;
        wr_valid = 1'b1;
        clear_mon();
        issue(1'b1, 1'b0, 16'h3000, 8'd2);
        for (int n = 2; n <= 7; n++) begin
            @(negedge clk);
            sample_cycle();
        end
        check("mr_in_strobe", {otg_hpi_w_n, otg_hpi_cs_n}, 2'b00);
        reset_reset_n = 1'b0;
        @(negedge clk);
        check("mr_pins", {otg_hpi_cs_n, otg_hpi_r_n, otg_hpi_w_n, otg_hpi_data_oe}, 4'b1110);
        check("mr_flags", {busy, done, cmd_ready}, 3'b000);
        release_wait(low, ok);
        check("mr_seq_low", low, EXP_RST_LOW);
        check("mr_ready", ok, 1);
        repeat (4) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("mr_no_done", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
